// File: rtl/vga_cursor_overlay_pkg.sv
// Shared VGA definitions: screen geometry defaults, cursor size and update-FSM encoding.
package vga_cursor_overlay_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int V_VISIBLE_DEF = 480;
    localparam int CURSOR_SIZE   = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } upd_state_t;

    function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/vga_cursor_overlay_cursor_rom.sv
// 16x16 arrow bitmap, one row per lookup; bit 15 is the leftmost column.
module cursor_rom (
    input  logic [3:0]  i_row,
    output logic [15:0] o_bits
);

    always_comb begin
        o_bits = 16'h0000;
        case (i_row)
            4'd0:  o_bits = 16'h8000;
            4'd1:  o_bits = 16'hC000;
            4'd2:  o_bits = 16'hE000;
            4'd3:  o_bits = 16'hF000;
            4'd4:  o_bits = 16'hF800;
            4'd5:  o_bits = 16'hFC00;
            4'd6:  o_bits = 16'hFE00;
            4'd7:  o_bits = 16'hFF00;
            4'd8:  o_bits = 16'hFF80;
            4'd9:  o_bits = 16'hFFC0;
            4'd10: o_bits = 16'hFFE0;
            4'd11: o_bits = 16'hFFF0;
            default: o_bits = 16'h1C00; // stem, columns 3..5
        endcase
    end

endmodule

// File: rtl/vga_cursor_overlay.sv
// Cursor overlay: position handshake with frame-synchronous update and zero-latency
// compositing of a 16x16 bitmap over the background pixel stream.
module vga_cursor_overlay
    import vga_cursor_overlay_pkg::*;
#(
    parameter int         H_VISIBLE    = H_VISIBLE_DEF,
    parameter int         V_VISIBLE    = V_VISIBLE_DEF,
    parameter logic [2:0] CURSOR_COLOR = 3'b111
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pixel_tick,
    input  logic       i_video_on,
    input  logic [9:0] i_pixel_x,
    input  logic [9:0] i_pixel_y,
    input  logic [2:0] i_bg_rgb,
    input  logic       i_cursor_en,
    input  logic       i_pos_valid,
    input  logic [9:0] i_pos_x,
    input  logic [9:0] i_pos_y,
    output logic       o_pos_ready,
    output logic [2:0] o_rgb,
    output logic       o_frame_tick,
    output logic [9:0] o_cur_x,
    output logic [9:0] o_cur_y
);

    localparam logic [9:0]  X_MAX = 10'(H_VISIBLE - 1);
    localparam logic [9:0]  Y_MAX = 10'(V_VISIBLE - 1);
    localparam logic [10:0] CSIZE = 11'(CURSOR_SIZE);

    upd_state_t r_state;
    logic       r_pos_ready;
    logic       r_frame_tick;
    logic       r_vblank_q;
    logic [9:0] r_shadow_x, r_shadow_y;
    logic [9:0] r_cur_x, r_cur_y;

    logic        w_vblank;
    logic        w_xfer;
    logic [10:0] w_px, w_py, w_cx, w_cy;
    logic        w_hit;
    logic [3:0]  w_row, w_col;
    logic [15:0] w_row_bits;
    logic        w_bit;

    assign w_vblank = (i_pixel_y >= 10'(V_VISIBLE));
    assign w_xfer   = i_pos_valid & r_pos_ready;

    // Sampler resets to 1 so a reset taken inside vblank does not fire a tick.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_pos_ready  <= 1'b1;
            r_frame_tick <= 1'b0;
            r_vblank_q   <= 1'b1;
            r_shadow_x   <= '0;
            r_shadow_y   <= '0;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
        end else begin
            r_frame_tick <= i_pixel_tick & w_vblank & ~r_vblank_q;
            if (i_pixel_tick)
                r_vblank_q <= w_vblank;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_shadow_x  <= clamp10(i_pos_x, X_MAX);
                        r_shadow_y  <= clamp10(i_pos_y, Y_MAX);
                        r_state     <= ST_PENDING;
                        r_pos_ready <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (r_frame_tick) begin
                        r_cur_x     <= r_shadow_x;
                        r_cur_y     <= r_shadow_y;
                        r_state     <= ST_IDLE;
                        r_pos_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // 11-bit compare keeps cursors near the right/bottom edge from wrapping to 0.
    assign w_px  = {1'b0, i_pixel_x};
    assign w_py  = {1'b0, i_pixel_y};
    assign w_cx  = {1'b0, r_cur_x};
    assign w_cy  = {1'b0, r_cur_y};
    assign w_hit = (w_px >= w_cx) && (w_px < w_cx + CSIZE) &&
                   (w_py >= w_cy) && (w_py < w_cy + CSIZE);

    assign w_row = i_pixel_y[3:0] - r_cur_y[3:0];
    assign w_col = i_pixel_x[3:0] - r_cur_x[3:0];

    cursor_rom u_rom (
        .i_row  (w_row),
        .o_bits (w_row_bits)
    );

    assign w_bit = w_row_bits[~w_col];

    assign o_rgb        = (i_cursor_en & i_video_on & w_hit & w_bit) ? CURSOR_COLOR : i_bg_rgb;
    assign o_pos_ready  = r_pos_ready;
    assign o_frame_tick = r_frame_tick;
    assign o_cur_x      = r_cur_x;
    assign o_cur_y      = r_cur_y;

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Self-checking bench: cycle model of the position/frame rules plus a geometric RGB reference.
module tb_vga_cursor_overlay;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       video_on = 1'b0;
    logic [9:0] px = '0, py = '0;
    logic [2:0] bg = '0;
    logic       en = 1'b0;
    logic       valid = 1'b0;
    logic [9:0] posx = '0, posy = '0;
    logic       ready;
    logic [2:0] rgb;
    logic       ft;
    logic [9:0] curx, cury;

    int n_vec = 0;
    int n_err = 0;

    // Reference state (what the spec says should be visible)
    bit m_pend = 0, m_ready = 1, m_ft = 0, m_vbs = 1;
    int m_sx = 0, m_sy = 0, m_cx = 0, m_cy = 0;

    always #5 clk = ~clk;

    vga_cursor_overlay dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_pixel_tick (tick),
        .i_video_on   (video_on),
        .i_pixel_x    (px),
        .i_pixel_y    (py),
        .i_bg_rgb     (bg),
        .i_cursor_en  (en),
        .i_pos_valid  (valid),
        .i_pos_x      (posx),
        .i_pos_y      (posy),
        .o_pos_ready  (ready),
        .o_rgb        (rgb),
        .o_frame_tick (ft),
        .o_cur_x      (curx),
        .o_cur_y      (cury)
    );

    // Arrow: triangle in rows 0..11 (column <= row), 3-wide stem at columns 3..5 below.
    function automatic bit ref_bit(input int r, input int c);
        if (r < 12) return (c <= r);
        return (c >= 3 && c <= 5);
    endfunction

    function automatic logic [2:0] ref_rgb(input int x, input int y, input bit e, input bit vo,
                                           input logic [2:0] b);
        bit hit;
        hit = (x >= m_cx) && (x < m_cx + 16) && (y >= m_cy) && (y < m_cy + 16);
        if (e && vo && hit && ref_bit(y - m_cy, x - m_cx)) return 3'b111;
        return b;
    endfunction

    task automatic step();
        bit xfer, ftn, vb;
        @(posedge clk);
        vb = (py >= 480);
        if (rst) begin
            m_pend = 0; m_ready = 1; m_ft = 0; m_vbs = 1;
            m_sx = 0; m_sy = 0; m_cx = 0; m_cy = 0;
        end else begin
            xfer = valid && m_ready;
            ftn  = tick && vb && !m_vbs;
            if (tick) m_vbs = vb;
            if (m_pend && m_ft) begin
                m_cx = m_sx; m_cy = m_sy; m_pend = 0;
            end else if (!m_pend && xfer) begin
                m_sx = (posx > 639) ? 639 : int'(posx);
                m_sy = (posy > 479) ? 479 : int'(posy);
                m_pend = 1;
            end
            m_ready = !m_pend;
            m_ft    = ftn;
        end
        #1;
        n_vec++;
        if (ft !== m_ft) begin n_err++; $display("FAIL frame_tick got=%b exp=%b t=%0t", ft, m_ft, $time); end
        n_vec++;
        if (ready !== m_ready) begin n_err++; $display("FAIL pos_ready got=%b exp=%b t=%0t", ready, m_ready, $time); end
        n_vec++;
        if (curx !== 10'(m_cx) || cury !== 10'(m_cy)) begin
            n_err++; $display("FAIL cur_xy got=%0d,%0d exp=%0d,%0d t=%0t", curx, cury, m_cx, m_cy, $time);
        end
    endtask

    task automatic probe(input int x, input int y, input bit e, input bit vo, input logic [2:0] b);
        logic [2:0] exp;
        tick = 0; px = 10'(x); py = 10'(y); en = e; video_on = vo; bg = b;
        #1;
        exp = ref_rgb(x, y, e, vo, b);
        n_vec++;
        if (rgb !== exp) begin
            n_err++; $display("FAIL rgb at (%0d,%0d) en=%b vo=%b got=%b exp=%b", x, y, e, vo, rgb, exp);
        end
        step();
    endtask

    task automatic check_cur(input string nm, input int ex, input int ey, input bit er);
        n_vec++;
        if (curx !== 10'(ex) || cury !== 10'(ey) || ready !== er) begin
            n_err++;
            $display("FAIL %s got cur=%0d,%0d rdy=%b exp cur=%0d,%0d rdy=%b", nm, curx, cury, ready, ex, ey, er);
        end
    endtask

    task automatic frame_boundary();
        tick = 1; py = 10'd0;   step();
        py = 10'd480;           step();
        n_vec++;
        if (ft !== 1'b1) begin n_err++; $display("FAIL frame_tick_pulse got=%b exp=1", ft); end
        py = 10'd481;           step();
        py = 10'd0;             step();
        tick = 0;
    endtask

    task automatic test_reset();
        rst = 1; valid = 1; posx = 10'd5; posy = 10'd5; step(); step();
        rst = 0; valid = 0;
        check_cur("reset_state", 0, 0, 1);
        tick = 1; py = 10'd500;
        repeat (3) begin
            step();
            n_vec++;
            if (ft !== 1'b0) begin n_err++; $display("FAIL no_spurious_tick got=%b exp=0", ft); end
        end
        for (int y = 0; y < 6; y++) begin py = 10'(y); step(); end
        check_cur("idle_frame", 0, 0, 1);
        frame_boundary();
        check_cur("after_first_frame", 0, 0, 1);
    endtask

    task automatic test_handshake();
        py = 10'd100; valid = 1; posx = 10'd100; posy = 10'd200; step();
        valid = 0; step();
        check_cur("pending_midframe", 0, 0, 0);
        repeat (5) step();
        check_cur("still_pending", 0, 0, 0);
        frame_boundary();
        check_cur("applied", 100, 200, 1);
    endtask

    task automatic test_draw();
        for (int y = 198; y < 218; y++)
            for (int x = 98; x < 118; x++)
                probe(x, y, 1, 1, 3'b001);
        probe(99, 200, 1, 1, 3'b001);
        probe(116, 200, 1, 1, 3'b001);
        probe(100, 200, 1, 1, 3'b001);
        probe(100, 200, 1, 0, 3'b001);
        probe(100, 200, 0, 1, 3'b010);
    endtask

    task automatic test_clamp();
        valid = 1; posx = 10'd700; posy = 10'd600; step();
        valid = 0;
        frame_boundary();
        check_cur("clamped", 639, 479, 1);
        probe(639, 479, 1, 1, 3'b000);
        probe(0, 479, 1, 1, 3'b000);
        probe(639, 0, 1, 1, 3'b000);
        probe(0, 0, 1, 1, 3'b000);
        probe(638, 479, 1, 1, 3'b000);
        for (int i = 0; i < 40; i++)
            probe($urandom_range(620, 659), $urandom_range(0, 20) < 10 ? $urandom_range(0, 15)
                  : $urandom_range(460, 499), 1, 1, 3'($urandom_range(0, 7)));
    endtask

    task automatic test_back_to_back();
        tick = 1; py = 10'd0; step();
        py = 10'd480; step();
        valid = 1; posx = 10'd50; posy = 10'd60; py = 10'd481; step();
        check_cur("xfer_in_tick_cycle", 639, 479, 0);
        posx = 10'd70; posy = 10'd80;
        repeat (4) step();
        check_cur("second_stalled", 639, 479, 0);
        py = 10'd0; step();
        py = 10'd480; step();
        step();
        check_cur("first_applied", 50, 60, 1);
        step();
        valid = 0;
        check_cur("second_accepted", 50, 60, 0);
        frame_boundary();
        check_cur("second_applied", 70, 80, 1);
    endtask

    task automatic test_reset_pending();
        valid = 1; posx = 10'd300; posy = 10'd300; step();
        valid = 0; step();
        rst = 1; step(); rst = 0;
        frame_boundary();
        check_cur("reset_discards", 0, 0, 1);
        rst = 1; valid = 1; posx = 10'd33; posy = 10'd44; step();
        rst = 0; valid = 0; step();
        frame_boundary();
        check_cur("reset_beats_xfer", 0, 0, 1);
        for (int i = 0; i < 30; i++)
            probe($urandom_range(0, 20), $urandom_range(0, 20), 0, 1, 3'($urandom_range(0, 7)));
    endtask

    task automatic test_random();
        int t;
        logic [2:0] exp;
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            valid = $urandom_range(0, 3) == 0;
            posx  = 10'($urandom_range(0, 1023));
            posy  = 10'($urandom_range(0, 1023));
            tick  = $urandom_range(0, 1);
            en    = $urandom_range(0, 7) != 0;
            video_on = $urandom_range(0, 7) != 0;
            bg    = 3'($urandom_range(0, 7));
            t = m_cx + $urandom_range(0, 21) - 3;
            if (t < 0) t = 0;
            px = 10'(t);
            if ($urandom_range(0, 9) < 2) t = $urandom_range(480, 524);
            else begin
                t = m_cy + $urandom_range(0, 21) - 3;
                if (t < 0) t = 0;
            end
            py = 10'(t);
            #1;
            exp = ref_rgb(int'(px), int'(py), en, video_on, bg);
            n_vec++;
            if (rgb !== exp) begin
                n_err++; $display("FAIL rand_rgb at (%0d,%0d) got=%b exp=%b", px, py, rgb, exp);
            end
            step();
        end
        rst = 0; valid = 0; tick = 0;
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_draw();
        test_clamp();
        test_back_to_back();
        test_reset_pending();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
